// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: two-flop synchroniser, counter stability filter,
// debounced level, single-cycle press/release strobes and optional hold-to-repeat strobes.
module btn_debounce_multi #(
   parameter int CHANNELS    = 5,
   parameter int STABLE_CNT  = 4,
   parameter int ACTIVE_LOW  = 0,
   parameter int REPEAT_EN   = 1,
   parameter int REPEAT_DLY  = 250,
   parameter int REPEAT_RATE = 50
) (
   input  logic                slow_clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] btn_raw,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] rpt,
   output logic                any_press
);

   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

   localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

   localparam logic [CHANNELS-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rstate_t;

   logic [CHANNELS-1:0] s1_reg;
   logic [CHANNELS-1:0] s2_reg;
   logic [CHANNELS-1:0] press_next;
   logic                any_press_reg;

   // Polarity is normalised before the synchroniser so everything downstream is 1 = pressed.
   always_ff @(posedge slow_clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_reg        <= '0;
         s2_reg        <= '0;
         any_press_reg <= 1'b0;
      end else begin
         s1_reg        <= btn_raw ^ POL_MASK;
         s2_reg        <= s1_reg;
         any_press_reg <= |press_next;
      end
   end

   assign any_press = any_press_reg;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [CW-1:0] cnt_reg;
         logic          level_reg;
         logic          press_reg;
         logic          release_reg;
         logic          accept;
         logic          rise;
         logic          fall;

         // The sample that completes a full run of mismatches flips the level this edge.
         assign accept = (s2_reg[gi] != level_reg) && (cnt_reg == CNT_LAST);
         assign rise   = accept & s2_reg[gi];
         assign fall   = accept & ~s2_reg[gi];
         assign press_next[gi] = rise;

         always_ff @(posedge slow_clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
            end else begin
               press_reg   <= rise;
               release_reg <= fall;
               if (s2_reg[gi] == level_reg) begin
                  cnt_reg <= '0;
               end else if (accept) begin
                  level_reg <= s2_reg[gi];
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
         end

         assign level[gi]         = level_reg;
         assign press[gi]         = press_reg;
         assign release_pulse[gi] = release_reg;

         if (REPEAT_EN != 0) begin : g_rpt
            rstate_t       state_reg;
            logic [RW-1:0] rcnt_reg;
            logic          rpt_reg;

            // A release seen this edge overrides any repeat pulse that would have fired.
            always_ff @(posedge slow_clk or negedge reset_n) begin
               if (!reset_n) begin
                  state_reg <= R_IDLE;
                  rcnt_reg  <= '0;
                  rpt_reg   <= 1'b0;
               end else begin
                  rpt_reg <= 1'b0;
                  if (fall) begin
                     state_reg <= R_IDLE;
                     rcnt_reg  <= '0;
                  end else begin
                     case (state_reg)
                        R_IDLE: begin
                           if (rise) begin
                              state_reg <= R_DELAY;
                              rcnt_reg  <= '0;
                           end
                        end
                        R_DELAY: begin
                           if (rcnt_reg == DLY_LAST) begin
                              rpt_reg   <= 1'b1;
                              rcnt_reg  <= '0;
                              state_reg <= R_REPEAT;
                           end else begin
                              rcnt_reg <= rcnt_reg + RW'(1);
                           end
                        end
                        R_REPEAT: begin
                           if (rcnt_reg == RATE_LAST) begin
                              rpt_reg  <= 1'b1;
                              rcnt_reg <= '0;
                           end else begin
                              rcnt_reg <= rcnt_reg + RW'(1);
                           end
                        end
                        default: begin
                           state_reg <= R_IDLE;
                           rcnt_reg  <= '0;
                        end
                     endcase
                  end
               end
            end

            assign rpt[gi] = rpt_reg;
         end else begin : g_norpt
            assign rpt[gi] = 1'b0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: hand sequences, a per-cycle vector table and
// randomised pins checked against a sliding-window / press-age reference model.
module tb_btn_debounce_multi;

   localparam int SC   = 4;
   localparam int DLY  = 8;
   localparam int RATE = 3;

   logic       slow_clk = 1'b0;
   logic       reset_n;
   logic [3:0] btn_raw;
   logic [3:0] level, press, rel, rpt;
   logic       any_press;
   logic [3:0] btn_raw2;
   logic [3:0] level2, press2, rel2, rpt2;
   logic       any2;

   always #5 slow_clk = ~slow_clk;

   btn_debounce_multi #(.CHANNELS(4), .STABLE_CNT(SC), .ACTIVE_LOW(0), .REPEAT_EN(1),
                        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)) dut (
      .slow_clk(slow_clk), .reset_n(reset_n), .btn_raw(btn_raw), .level(level),
      .press(press), .release_pulse(rel), .rpt(rpt), .any_press(any_press));

   btn_debounce_multi #(.CHANNELS(4), .STABLE_CNT(SC), .ACTIVE_LOW(1), .REPEAT_EN(1),
                        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)) dut_al (
      .slow_clk(slow_clk), .reset_n(reset_n), .btn_raw(btn_raw2), .level(level2),
      .press(press2), .release_pulse(rel2), .rpt(rpt2), .any_press(any2));

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state
   logic [3:0] pipe[$];
   logic [3:0] win[$];
   logic [3:0] m_level, m_press, m_rel, m_rpt;
   logic       m_any;
   int         age[4];

   typedef struct {
      logic [3:0] raw;
      logic [3:0] level;
      logic [3:0] press;
      logic [3:0] rel;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      pipe = '{4'h0, 4'h0};
      win.delete();
      m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_any = 1'b0;
      for (int c = 0; c < 4; c++) age[c] = 0;
   endtask

   // Level flips when the last SC synchronised samples all disagree with it;
   // repeats fire at press ages DLY, DLY+RATE, DLY+2*RATE, ...
   task automatic model_edge();
      logic [3:0] x, w;
      logic acc;
      if (!reset_n) return;
      x = pipe.pop_front();
      pipe.push_back(btn_raw);
      win.push_back(x);
      if (win.size() > SC) void'(win.pop_front());
      m_press = '0; m_rel = '0; m_rpt = '0;
      for (int c = 0; c < 4; c++) begin
         acc = (win.size() == SC);
         for (int k = 0; k < win.size(); k++) begin
            w = win[k];
            if (w[c] == m_level[c]) acc = 1'b0;
         end
         if (acc) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) begin
               m_press[c] = 1'b1;
               age[c] = 0;
            end else begin
               m_rel[c] = 1'b1;
            end
         end else if (m_level[c]) begin
            age[c]++;
            if (age[c] >= DLY && ((age[c] - DLY) % RATE) == 0) m_rpt[c] = 1'b1;
         end
      end
      m_any = |m_press;
   endtask

   task automatic model_cmp();
      chk("level", level, m_level);
      chk("press", press, m_press);
      chk("release", rel, m_rel);
      chk("rpt", rpt, m_rpt);
      chk("any_press", {3'b0, any_press}, {3'b0, m_any});
   endtask

   task automatic tick();
      @(posedge slow_clk);
      model_edge();
      @(negedge slow_clk);
      model_cmp();
   endtask

   task automatic async_reset();
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_level", level, 4'h0);
      chk("rst_press", press, 4'h0);
      chk("rst_any", {3'b0, any_press}, 4'h0);
   endtask

   int first_rpt, rpt_hold, rpt_rel, rpt_after, rel_tick;

   initial begin
      tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[3]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[4]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[5]  = '{4'h1, 4'h1, 4'h1, 4'h0};
      tbl[6]  = '{4'h1, 4'h1, 4'h0, 4'h0};
      tbl[7]  = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[8]  = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[9]  = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[10] = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[11] = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[12] = '{4'h0, 4'h0, 4'h0, 4'h1};
      tbl[13] = '{4'h0, 4'h0, 4'h0, 4'h0};

      // Reset with all buttons held
      btn_raw  = 4'hF;
      btn_raw2 = 4'hF;
      reset_n  = 1'b1;
      model_reset();
      #2;
      async_reset();
      chk("rst_release", rel, 4'h0);
      chk("rst_rpt", rpt, 4'h0);
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("t1_level", level, (i >= 6) ? 4'hF : 4'h0);
         chk("t1_press", press, (i == 6) ? 4'hF : 4'h0);
         chk("t1_any", {3'b0, any_press}, (i == 6) ? 4'h1 : 4'h0);
      end
      btn_raw = 4'h0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("t1_release", rel, (i == 6) ? 4'hF : 4'h0);
      end

      // Clean step on channel 0, one table row per edge
      for (int i = 0; i < 14; i++) begin
         btn_raw = tbl[i].raw;
         tick();
         chk("tbl_level", level, tbl[i].level);
         chk("tbl_press", press, tbl[i].press);
         chk("tbl_release", rel, tbl[i].rel);
      end
      for (int i = 0; i < 4; i++) tick();

      // Bounce on channel 1
      for (int i = 0; i < 8; i++) begin
         btn_raw = (i % 4 < 2) ? 4'h2 : 4'h0;
         tick();
         chk("t3_bounce_press", press, 4'h0);
         chk("t3_bounce_level", level, 4'h0);
      end
      btn_raw = 4'h2;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("t3_press", press, (i == 6) ? 4'h2 : 4'h0);
      end
      btn_raw = 4'h0;
      for (int i = 0; i < 8; i++) tick();

      // Hold-to-repeat on channel 2
      btn_raw = 4'h4;
      first_rpt = -1; rpt_hold = 0; rpt_rel = 0; rpt_after = 0; rel_tick = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (rpt[2]) begin
            rpt_hold++;
            if (first_rpt < 0) first_rpt = i;
         end
         if (i == 6) chk("t4_press", press, 4'h4);
      end
      btn_raw = 4'h0;
      for (int i = 31; i <= 50; i++) begin
         tick();
         if (rel[2]) rel_tick = i;
         if (rpt[2]) begin
            if (rel_tick < 0) rpt_rel++;
            else rpt_after++;
         end
      end
      chk("t4_first_rpt", 4'(first_rpt), 4'(14));
      chk("t4_rpt_hold", 4'(rpt_hold), 4'(6));
      chk("t4_rpt_before_rel", 4'(rpt_rel), 4'(2));
      chk("t4_rel_tick", 4'(rel_tick - 30), 4'(6));
      chk("t4_rpt_after", 4'(rpt_after), 4'(0));

      // Active-low instance, two channels pressed together
      btn_raw2 = 4'h5;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("t5_press", press2, (i == 6) ? 4'hA : 4'h0);
         chk("t5_any", {3'b0, any2}, (i == 6) ? 4'h1 : 4'h0);
         chk("t5_level", level2, (i >= 6) ? 4'hA : 4'h0);
      end

      // Reset mid-filter on channel 3
      btn_raw = 4'h8;
      for (int i = 0; i < 4; i++) tick();
      async_reset();
      tick();
      reset_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("t6_level", level, (i >= 6) ? 4'h8 : 4'h0);
         chk("t6_press", press, (i == 6) ? 4'h8 : 4'h0);
      end
      btn_raw = 4'h0;
      for (int i = 0; i < 8; i++) tick();

      // Randomised pins against the reference model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) btn_raw[$urandom_range(0, 3)] ^= 1'b1;
         if (i == 300) begin
            async_reset();
            tick();
            reset_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
